matrix_result_streamer: RTL and testbench

//   Reader side of the multiplier result bus. Detects rdy rising, snapshots the flat

---
 rtl/matrix_result_streamer.sv | 135 +++++++++++++
 tb/tb_matrix_result_streamer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: snapshots the flat multiplier result bus on a rising
// rdy and streams its order*order elements row-major over valid/ready, with
// row/column indices, a last flag, a done pulse and a sticky overrun flag.
module matrix_result_streamer #(
  parameter int order    = 2,
  parameter int bitwidth = 16,
  localparam int RW      = (order > 1) ? $clog2(order) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2*order*order*bitwidth-1:0] C,
  input  logic                              rdy,
  output logic [bitwidth-1:0]               out_data,
  output logic [RW-1:0]                     out_row,
  output logic [RW-1:0]                     out_col,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              overrun
);

  localparam int ELEMS = order * order;
  localparam int IW    = $clog2(ELEMS);
  localparam logic [IW-1:0] LAST     = IW'(ELEMS - 1);
  localparam logic [IW-1:0] ORDER_IW = IW'(order);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       index, index_n;
  logic                rdy_q;
  logic                rise;
  logic                load;
  logic [bitwidth-1:0] buffer [ELEMS];

  logic [bitwidth-1:0] out_data_n;
  logic [RW-1:0]       out_row_n, out_col_n;
  logic                out_valid_n, out_last_n, busy_n, done_n, overrun_n;

  // Upper half of C is never used by this reader.
  logic unused_c_hi;
  assign unused_c_hi = ^C[2*ELEMS*bitwidth-1:ELEMS*bitwidth];

  assign rise = rdy & ~rdy_q;

  // Snapshot of the result bus, captured only when a stream is launched.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned k = 0; k < ELEMS; k++) begin
        buffer[k] <= C[k*bitwidth +: bitwidth];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      rdy_q     <= 1'b1;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      rdy_q     <= rdy;
      out_data  <= out_data_n;
      out_row   <= out_row_n;
      out_col   <= out_col_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
      done      <= done_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state and next-output decode; outputs hold unless a transfer occurs.
  always_comb begin
    state_n     = state;
    index_n     = index;
    load        = 1'b0;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    busy_n      = busy;
    done_n      = 1'b0;
    overrun_n   = overrun | (rise & (state != IDLE));

    case (state)
      IDLE: begin
        if (rise) begin
          load        = 1'b1;
          index_n     = '0;
          out_data_n  = C[bitwidth-1:0];
          out_valid_n = 1'b1;
          out_last_n  = 1'b0;
          busy_n      = 1'b1;
          state_n     = STREAM;
        end
      end
      STREAM: begin
        if (out_valid & out_ready) begin
          if (index == LAST) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            done_n      = 1'b1;
            state_n     = DONE;
          end else begin
            index_n    = index + IW'(1);
            out_data_n = buffer[index_n];
            out_last_n = (index_n == LAST);
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    out_row_n = RW'(index_n / ORDER_IW);
    out_col_n = RW'(index_n % ORDER_IW);
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: order=2/bitwidth=16 instance for
// streaming, backpressure, snapshot, overrun and reset; order=3/bitwidth=8 for
// row-major index walking.
module tb_matrix_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // order=2, bitwidth=16 instance
  logic [127:0] C2;
  logic         rdy2, ready2;
  logic [15:0]  data2;
  logic [0:0]   row2, col2;
  logic         valid2, last2, busy2, done2, ovr2;

  // order=3, bitwidth=8 instance
  logic [143:0] C3;
  logic         rdy3, ready3;
  logic [7:0]   data3;
  logic [1:0]   row3, col3;
  logic         valid3, last3, busy3, done3, ovr3;

  matrix_result_streamer #(.order(2), .bitwidth(16)) dut2 (
    .clk(clk), .reset(reset), .C(C2), .rdy(rdy2),
    .out_data(data2), .out_row(row2), .out_col(col2), .out_valid(valid2),
    .out_ready(ready2), .out_last(last2), .busy(busy2), .done(done2),
    .overrun(ovr2)
  );

  matrix_result_streamer #(.order(3), .bitwidth(8)) dut3 (
    .clk(clk), .reset(reset), .C(C3), .rdy(rdy3),
    .out_data(data3), .out_row(row3), .out_col(col3), .out_valid(valid3),
    .out_ready(ready3), .out_last(last3), .busy(busy3), .done(done3),
    .overrun(ovr3)
  );

  localparam logic [127:0] C2_GOOD =
    {64'hA5A5_5A5A_C3C3_3C3C, 16'h0032, 16'h002B, 16'h0016, 16'h0013};
  logic [15:0] exp2 [4] = '{16'h0013, 16'h0016, 16'h002B, 16'h0032};

  int n_checks = 0;
  int n_fail   = 0;

  // Capture state filled by drain()
  logic [15:0] cap_data [16];
  int          cap_row  [16];
  int          cap_col  [16];
  logic        cap_last [16];
  int          n_beats, hold_errs, done_cnt, done_gap;
  logic        timed_out;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives out_ready from pat (then 1s), records accepted beats, counts
  // changes while stalled, and stops two samples after the last beat once done seen.
  task automatic drain(input logic [15:0] pat, input int pat_len, input int budget);
    logic [15:0] h_data;
    logic [0:0]  h_row, h_col;
    logic        h_last, h_pend;
    int          last_c;
    n_beats = 0; hold_errs = 0; done_cnt = 0; done_gap = -1;
    timed_out = 1'b1; h_pend = 1'b0; last_c = 0;
    h_data = '0; h_row = '0; h_col = '0; h_last = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (h_pend && (data2 !== h_data || row2 !== h_row || col2 !== h_col ||
                     last2 !== h_last || valid2 !== 1'b1))
        hold_errs++;
      ready2 = (c < pat_len) ? pat[c] : 1'b1;
      if (done2 === 1'b1) begin
        done_cnt++;
        if (done_gap < 0) done_gap = c - last_c;
      end
      if (valid2 === 1'b1 && ready2) begin
        if (n_beats < 16) begin
          cap_data[n_beats] = data2;
          cap_row[n_beats]  = int'(row2);
          cap_col[n_beats]  = int'(col2);
          cap_last[n_beats] = last2;
        end
        n_beats++;
        last_c = c;
        h_pend = 1'b0;
      end else if (valid2 === 1'b1) begin
        h_data = data2; h_row = row2; h_col = col2; h_last = last2;
        h_pend = 1'b1;
      end else begin
        h_pend = 1'b0;
      end
      if (done_cnt > 0 && c >= last_c + 2) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (data2 !== 16'h0 || row2 !== 1'b0 || col2 !== 1'b0 || valid2 !== 1'b0 ||
        last2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || ovr2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_o2: data=%h row=%b col=%b v=%b l=%b busy=%b done=%b ovr=%b, want all 0",
               data2, row2, col2, valid2, last2, busy2, done2, ovr2);
    end
    n_checks++;
    if (data3 !== 8'h0 || valid3 !== 1'b0 || busy3 !== 1'b0 || ovr3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_o3: data=%h v=%b busy=%b ovr=%b, want all 0", data3, valid3, busy3, ovr3);
    end
  endtask

  task automatic test_stream;
    int extra;
    rdy2 = 1'b0; ready2 = 1'b1; tick();
    rdy2 = 1'b1;
    tick();
    n_checks++;
    if (valid2 !== 1'b1 || data2 !== 16'h0013 || busy2 !== 1'b1 || last2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_latency: v=%b data=%h busy=%b last=%b, want v=1 data=0013 busy=1 last=0",
               valid2, data2, busy2, last2);
    end
    drain(16'hFFFF, 16, 40);
    n_checks++;
    if (timed_out !== 1'b0 || n_beats !== 4) begin
      n_fail++;
      $display("FAIL stream_count: timeout=%b beats=%0d, want 0 and 4", timed_out, n_beats);
    end
    for (int i = 0; i < n_beats && i < 4; i++) begin
      n_checks++;
      if (cap_data[i] !== exp2[i] || cap_row[i] !== i / 2 || cap_col[i] !== i % 2 ||
          cap_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got %h (%0d,%0d) last=%b, want %h (%0d,%0d) last=%b",
                 i, cap_data[i], cap_row[i], cap_col[i], cap_last[i],
                 exp2[i], i / 2, i % 2, (i == 3));
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_gap !== 1 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done: pulses=%0d gap=%0d busy=%b, want 1 1 0", done_cnt, done_gap, busy2);
    end
    // rdy stays high: no second stream may start
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid2 === 1'b1 || done2 === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL rdy_level_no_retrigger: active cycles=%0d, want 0", extra);
    end
  endtask

  task automatic test_backpressure;
    rdy2 = 1'b0; tick();
    rdy2 = 1'b1; tick();
    drain(16'h0069, 7, 40);
    n_checks++;
    if (timed_out !== 1'b0 || n_beats !== 4 || hold_errs !== 0) begin
      n_fail++;
      $display("FAIL bp_count: timeout=%b beats=%0d hold_errs=%0d, want 0 4 0",
               timed_out, n_beats, hold_errs);
    end
    for (int i = 0; i < n_beats && i < 4; i++) begin
      n_checks++;
      if (cap_data[i] !== exp2[i] || cap_row[i] !== i / 2 || cap_col[i] !== i % 2 ||
          cap_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h (%0d,%0d) last=%b, want %h (%0d,%0d) last=%b",
                 i, cap_data[i], cap_row[i], cap_col[i], cap_last[i],
                 exp2[i], i / 2, i % 2, (i == 3));
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_gap !== 1) begin
      n_fail++;
      $display("FAIL bp_done: pulses=%0d gap=%0d, want 1 1", done_cnt, done_gap);
    end
  endtask

  task automatic test_snapshot;
    rdy2 = 1'b0; tick();
    rdy2 = 1'b1; tick();
    C2 = '1;
    drain(16'h0005, 4, 40);
    n_checks++;
    if (timed_out !== 1'b0 || n_beats !== 4) begin
      n_fail++;
      $display("FAIL snap_count: timeout=%b beats=%0d, want 0 4", timed_out, n_beats);
    end
    for (int i = 0; i < n_beats && i < 4; i++) begin
      n_checks++;
      if (cap_data[i] !== exp2[i]) begin
        n_fail++;
        $display("FAIL snap_beat%0d: got %h want %h", i, cap_data[i], exp2[i]);
      end
    end
    C2 = C2_GOOD;
  endtask

  task automatic test_overrun;
    n_checks++;
    if (ovr2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear_before: got %b want 0", ovr2);
    end
    rdy2 = 1'b0; ready2 = 1'b0; tick();
    rdy2 = 1'b1; tick();
    rdy2 = 1'b0; C2 = {64'h0, 64'h1111_2222_3333_4444}; tick();
    rdy2 = 1'b1; tick();
    n_checks++;
    if (ovr2 !== 1'b1 || valid2 !== 1'b1 || data2 !== 16'h0013) begin
      n_fail++;
      $display("FAIL ovr_set: ovr=%b v=%b data=%h, want 1 1 0013", ovr2, valid2, data2);
    end
    drain(16'hFFFF, 16, 40);
    n_checks++;
    if (timed_out !== 1'b0 || n_beats !== 4) begin
      n_fail++;
      $display("FAIL ovr_count: timeout=%b beats=%0d, want 0 4", timed_out, n_beats);
    end
    for (int i = 0; i < n_beats && i < 4; i++) begin
      n_checks++;
      if (cap_data[i] !== exp2[i]) begin
        n_fail++;
        $display("FAIL ovr_beat%0d: got %h want %h", i, cap_data[i], exp2[i]);
      end
    end
    n_checks++;
    if (ovr2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b want 1", ovr2);
    end
    C2 = C2_GOOD;
  endtask

  task automatic test_mid_reset;
    int active;
    rdy2 = 1'b0; ready2 = 1'b1; tick();
    rdy2 = 1'b1; tick();
    tick();
    tick();
    n_checks++;
    if (valid2 !== 1'b1 || data2 !== 16'h002B) begin
      n_fail++;
      $display("FAIL mid_pre_reset: v=%b data=%h, want 1 002b", valid2, data2);
    end
    reset = 1'b1; tick();
    n_checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || ovr2 !== 1'b0 ||
        data2 !== 16'h0 || last2 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: v=%b busy=%b done=%b ovr=%b data=%h last=%b, want 0s",
               valid2, busy2, done2, ovr2, data2, last2);
    end
    reset = 1'b0;
    active = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid2 === 1'b1 || done2 === 1'b1 || busy2 === 1'b1) active++;
    end
    n_checks++;
    if (active !== 0) begin
      n_fail++;
      $display("FAIL mid_no_restart: active cycles=%0d, want 0", active);
    end
    rdy2 = 1'b0; tick();
    rdy2 = 1'b1; tick();
    n_checks++;
    if (valid2 !== 1'b1 || data2 !== 16'h0013) begin
      n_fail++;
      $display("FAIL mid_rearm: v=%b data=%h, want 1 0013", valid2, data2);
    end
    drain(16'hFFFF, 16, 40);
    n_checks++;
    if (timed_out !== 1'b0 || n_beats !== 4) begin
      n_fail++;
      $display("FAIL mid_rearm_count: timeout=%b beats=%0d, want 0 4", timed_out, n_beats);
    end
  endtask

  task automatic test_order3;
    int          k;
    int          dcnt;
    logic [7:0]  e;
    for (int i = 0; i < 9; i++) C3[i*8 +: 8] = 8'(8'hA0 + i);
    C3[143:72] = '1;
    ready3 = 1'b1;
    rdy3 = 1'b1;
    tick();
    k = 0; dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done3 === 1'b1) dcnt++;
      if (valid3 === 1'b1 && ready3) begin
        e = 8'(8'hA0 + k);
        n_checks++;
        if (data3 !== e || int'(row3) !== k / 3 || int'(col3) !== k % 3 || last3 !== (k == 8)) begin
          n_fail++;
          $display("FAIL o3_beat%0d: got %h (%0d,%0d) last=%b, want %h (%0d,%0d) last=%b",
                   k, data3, row3, col3, last3, e, k / 3, k % 3, (k == 8));
        end
        k++;
      end
      if (dcnt > 0) break;
      tick();
    end
    n_checks++;
    if (k !== 9 || dcnt !== 1) begin
      n_fail++;
      $display("FAIL o3_count: beats=%0d done=%0d, want 9 1", k, dcnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    C2 = C2_GOOD; rdy2 = 1'b0; ready2 = 1'b0;
    C3 = '0;      rdy3 = 1'b0; ready3 = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_stream();
    test_backpressure();
    test_snapshot();
    test_overrun();
    test_mid_reset();
    test_order3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
